// File: rtl/rom_sequencer_if.sv
// Bus bundle between the ROM sequencer, the ROM data/address pins and the downstream consumer.
// Latency: none (wiring only).
// Backpressure: ready from the consumer stalls the word held under valid.
//
// Signals:
//   start    : begin a sweep (honoured only while the sequencer is idle)
//   addr     : ROM address driven by the sequencer
//   d_rom    : ROM read data returned to the sequencer
//   d_out    : word presented downstream, qualified by valid
//   valid    : d_out holds a word
//   ready    : consumer accepts the word
//   busy     : sequencer is not idle
//   done     : one-cycle pulse after the last word is accepted
//   checksum : running sum of accepted words, mod 2^DATA_W
interface rom_sequencer_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] d_rom;
  logic [DATA_W-1:0] d_out;
  logic              valid;
  logic              ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  // Sequencer side.
  modport master (
    input  start, d_rom, ready,
    output addr, d_out, valid, busy, done, checksum
  );

  // Environment side: ROM and consumer.
  modport slave (
    output start, d_rom, ready,
    input  addr, d_out, valid, busy, done, checksum
  );
endinterface

// File: rtl/rom_sequencer.sv
// Streams every ROM word (addresses 0..2^ADDR_W-1) downstream in order, then reports a modular checksum.
// Latency: 2+ROM_LAT cycles per word (issue, ROM_LAT wait cycles, one output cycle); done one cycle after the last handshake.
// Backpressure: the word is held under valid while ready=0; each stalled cycle adds exactly one cycle.
//
// Ports:
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset, dominates every other input
//   bus   : rom_sequencer_if.master (start, addr, d_rom, d_out, valid, ready, busy, done, checksum)
// All outputs are registered; no input reaches an output combinationally.
module rom_sequencer #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1   // ROM read latency, 1..4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  rom_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_idx;     // doubles as the registered ROM address
  logic [2:0]        r_wcnt;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_sum;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_last_idx;

  assign w_last_idx = (r_idx == {ADDR_W{1'b1}});

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (r_wcnt == 3'd1) w_state_nxt = S_OUT;
      S_OUT: begin
        if (bus.ready) w_state_nxt = w_last_idx ? S_DONE : S_ISSUE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus datapath. Status outputs are registered from the
  // next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wcnt  <= '0;
      r_dout  <= '0;
      r_sum   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == S_OUT);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_idx <= '0;
            r_sum <= '0;
          end
        end
        S_ISSUE: begin
          // The ROM samples addr at the edge that leaves ISSUE; count its latency from there.
          r_wcnt <= 3'(ROM_LAT);
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt - 3'd1;
          if (r_wcnt == 3'd1) r_dout <= bus.d_rom;
        end
        S_OUT: begin
          if (bus.ready) begin
            r_sum <= r_sum + r_dout;
            // Final index is held so addr stays at the last address through DONE and IDLE.
            if (!w_last_idx) r_idx <= r_idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.addr     = r_idx;
  assign bus.d_out    = r_dout;
  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.checksum = r_sum;

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: two instances (ROM_LAT=1 and ROM_LAT=3), each fed by a
// ROM model returning 8'hA0+addr. A per-cycle compare process tracks which word
// must be on the bus and the running checksum; directed tasks pin latency, sweep
// length, back-pressure, ignored starts and mid-sweep reset with literal values.
module tb_rom_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  rom_sequencer_if #(.ADDR_W(3), .DATA_W(8)) bus1 ();
  rom_sequencer_if #(.ADDR_W(3), .DATA_W(8)) bus3 ();

  logic       a_rst[2];
  logic       a_start[2];
  logic       a_ready[2];
  logic       a_valid[2];
  logic       a_busy[2];
  logic       a_done[2];
  logic [7:0] a_dout[2];
  logic [7:0] a_sum[2];
  logic [2:0] a_addr[2];

  rom_sequencer #(.ADDR_W(3), .DATA_W(8), .ROM_LAT(1)) dut1 (
    .i_clk(clk), .i_rst(a_rst[0]), .bus(bus1.master)
  );
  rom_sequencer #(.ADDR_W(3), .DATA_W(8), .ROM_LAT(3)) dut3 (
    .i_clk(clk), .i_rst(a_rst[1]), .bus(bus3.master)
  );

  assign bus1.start = a_start[0];
  assign bus1.ready = a_ready[0];
  assign bus3.start = a_start[1];
  assign bus3.ready = a_ready[1];

  assign a_valid[0] = bus1.valid;    assign a_valid[1] = bus3.valid;
  assign a_busy[0]  = bus1.busy;     assign a_busy[1]  = bus3.busy;
  assign a_done[0]  = bus1.done;     assign a_done[1]  = bus3.done;
  assign a_dout[0]  = bus1.d_out;    assign a_dout[1]  = bus3.d_out;
  assign a_sum[0]   = bus1.checksum; assign a_sum[1]   = bus3.checksum;
  assign a_addr[0]  = bus1.addr;     assign a_addr[1]  = bus3.addr;

  // ROM models: registered read, content A0+addr, latency 1 and 3.
  logic [7:0] rom1_q;
  logic [7:0] rom3_q[3];
  always @(posedge clk) begin
    rom1_q    <= 8'hA0 + {5'd0, bus1.addr};
    rom3_q[0] <= 8'hA0 + {5'd0, bus3.addr};
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign bus1.d_rom = rom1_q;
  assign bus3.d_rom = rom3_q[2];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // Model view: a sweep is "deliver words A0+i for i=0..7 in order; the
  // checksum is the sum of those accepted so far; done follows the 8th accept".
  bit         chk_en = 1'b0;
  int         m_idx[2]      = '{0, 0};
  logic [7:0] m_sum[2]      = '{8'h00, 8'h00};
  bit         m_exp_done[2] = '{1'b0, 1'b0};
  bit         m_exp_rst[2]  = '{1'b0, 1'b0};
  bit         m_hold[2]     = '{1'b0, 1'b0};
  logic [7:0] m_held[2]     = '{8'h00, 8'h00};

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        if (m_exp_rst[k]) begin
          chk("rst_valid", k, {31'd0, a_valid[k]}, 32'd0);
          chk("rst_busy",  k, {31'd0, a_busy[k]},  32'd0);
          chk("rst_addr",  k, {29'd0, a_addr[k]},  32'd0);
          chk("rst_sum",   k, {24'd0, a_sum[k]},   32'd0);
        end
        chk("done", k, {31'd0, a_done[k]}, {31'd0, m_exp_done[k]});
        if (a_valid[k]) begin
          chk("word",     k, {24'd0, a_dout[k]}, 32'(8'(8'hA0 + m_idx[k])));
          chk("addr",     k, {29'd0, a_addr[k]}, 32'(m_idx[k]));
          chk("run_sum",  k, {24'd0, a_sum[k]},  {24'd0, m_sum[k]});
          chk("busy_out", k, {31'd0, a_busy[k]}, 32'd1);
        end
        if (m_hold[k]) begin
          chk("stall_valid", k, {31'd0, a_valid[k]}, 32'd1);
          chk("stall_hold",  k, {24'd0, a_dout[k]},  {24'd0, m_held[k]});
        end
        if (a_done[k]) begin
          chk("final_sum",  k, {24'd0, a_sum[k]},  {24'd0, m_sum[k]});
          chk("final_addr", k, {29'd0, a_addr[k]}, 32'd7);
        end

        // Advance the model across the coming edge.
        m_exp_rst[k]  = 1'b0;
        m_exp_done[k] = 1'b0;
        m_hold[k]     = 1'b0;
        if (a_rst[k]) begin
          m_idx[k]     = 0;
          m_sum[k]     = 8'h00;
          m_exp_rst[k] = 1'b1;
        end else begin
          if (a_valid[k] && a_ready[k]) begin
            m_sum[k] = 8'(m_sum[k] + 8'(8'hA0 + m_idx[k]));
            if (m_idx[k] == 7) m_exp_done[k] = 1'b1;
            else               m_idx[k]++;
          end else if (a_valid[k]) begin
            m_hold[k] = 1'b1;
            m_held[k] = a_dout[k];
          end
          if (!a_busy[k] && a_start[k]) begin
            m_idx[k] = 0;
            m_sum[k] = 8'h00;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep on instance k. first_lat counts edges with the start-sampling
  // edge as the first; total counts edges after that one until done is seen.
  task automatic sweep(input int k, input int bp_word, input int bp_len, input bit pokes,
                       output int first_lat, output int total, output int ndone);
    int n;
    int post;
    int bp_left;
    bit bp_done;
    bit a2_done;
    first_lat = -1; total = -1; ndone = 0;
    n = 0; post = 0; bp_left = 0; bp_done = 1'b0; a2_done = 1'b0;
    a_start[k] = 1'b1;
    tick();
    a_start[k] = 1'b0;
    while (post < 4 && n < 200) begin
      tick();
      n++;
      a_start[k] = 1'b0;
      if (a_valid[k] && first_lat < 0) first_lat = n + 1;
      if (a_done[k]) begin
        ndone++;
        total = n;
        if (pokes) a_start[k] = 1'b1;   // lands in the DONE cycle
      end
      if (total >= 0) post++;
      if (pokes && a_valid[k] && a_dout[k] == 8'hA2 && !a2_done) begin
        a_start[k] = 1'b1;
        a2_done    = 1'b1;
      end
      if (bp_left > 0) begin
        chk("bp_valid", k, {31'd0, a_valid[k]}, 32'd1);
        chk("bp_word",  k, {24'd0, a_dout[k]},  32'(8'(8'hA0 + bp_word)));
        bp_left--;
        if (bp_left == 0) a_ready[k] = 1'b1;
      end else if (bp_len > 0 && !bp_done && a_valid[k] && a_dout[k] == 8'(8'hA0 + bp_word)) begin
        a_ready[k] = 1'b0;
        bp_left    = bp_len;
        bp_done    = 1'b1;
      end
    end
    a_start[k] = 1'b0;
    a_ready[k] = 1'b1;
    if (total < 0) begin
      checks++;
      failures++;
      $display("FAIL sweep_timeout inst%0d: no done within %0d cycles", k, n);
    end
  endtask

  int lat, tot, nd;

  initial begin
    a_rst   = '{1'b1, 1'b1};
    a_start = '{1'b1, 1'b1};
    a_ready = '{1'b1, 1'b1};
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    // Reset held with start=1: everything zero.
    for (int k = 0; k < 2; k++) begin
      chk("reset_valid", k, {31'd0, a_valid[k]}, 32'd0);
      chk("reset_busy",  k, {31'd0, a_busy[k]},  32'd0);
      chk("reset_done",  k, {31'd0, a_done[k]},  32'd0);
      chk("reset_dout",  k, {24'd0, a_dout[k]},  32'd0);
      chk("reset_sum",   k, {24'd0, a_sum[k]},   32'd0);
      chk("reset_addr",  k, {29'd0, a_addr[k]},  32'd0);
    end
    a_rst   = '{1'b0, 1'b0};
    a_start = '{1'b0, 1'b0};
    tick();
    chk("idle_after_reset", 0, {31'd0, a_busy[0]}, 32'd0);

    // Full sweep, ready held high.
    sweep(0, 0, 0, 1'b0, lat, tot, nd);
    chk("first_valid_edges", 0, 32'(lat), 32'd3);
    chk("sweep_edges",       0, 32'(tot), 32'd24);
    chk("done_pulses",       0, 32'(nd),  32'd1);
    chk("sum_1C",            0, {24'd0, a_sum[0]}, 32'h1C);
    chk("idle_busy",         0, {31'd0, a_busy[0]}, 32'd0);

    // Back-pressure: ready low for 5 cycles while A3 is presented.
    sweep(0, 3, 5, 1'b0, lat, tot, nd);
    chk("bp_sweep_edges", 0, 32'(tot), 32'd29);
    chk("bp_done_pulses", 0, 32'(nd),  32'd1);
    chk("bp_sum_1C",      0, {24'd0, a_sum[0]}, 32'h1C);

    // Starts at A2 and in the DONE cycle are ignored.
    sweep(0, 0, 0, 1'b1, lat, tot, nd);
    chk("poke_sweep_edges", 0, 32'(tot), 32'd24);
    chk("poke_done_pulses", 0, 32'(nd),  32'd1);
    chk("poke_idle_busy",   0, {31'd0, a_busy[0]}, 32'd0);
    chk("poke_addr_held",   0, {29'd0, a_addr[0]}, 32'd7);

    // Mid-sweep reset while A5 is valid.
    a_start[0] = 1'b1;
    tick();
    a_start[0] = 1'b0;
    begin
      int n;
      n = 0;
      while (!(a_valid[0] && a_dout[0] == 8'hA5) && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) begin
        checks++;
        failures++;
        $display("FAIL wait_A5 inst0: word A5 not seen within %0d cycles", n);
      end
    end
    a_rst[0] = 1'b1;
    tick();
    chk("midrst_valid", 0, {31'd0, a_valid[0]}, 32'd0);
    chk("midrst_addr",  0, {29'd0, a_addr[0]},  32'd0);
    chk("midrst_sum",   0, {24'd0, a_sum[0]},   32'd0);
    chk("midrst_busy",  0, {31'd0, a_busy[0]},  32'd0);
    a_rst[0] = 1'b0;
    tick();
    sweep(0, 0, 0, 1'b0, lat, tot, nd);
    chk("rerun_first_edges", 0, 32'(lat), 32'd3);
    chk("rerun_sweep_edges", 0, 32'(tot), 32'd24);
    chk("rerun_sum_1C",      0, {24'd0, a_sum[0]}, 32'h1C);

    // ROM_LAT=3 instance.
    sweep(1, 0, 0, 1'b0, lat, tot, nd);
    chk("lat3_first_edges", 1, 32'(lat), 32'd5);
    chk("lat3_sweep_edges", 1, 32'(tot), 32'd40);
    chk("lat3_done_pulses", 1, 32'(nd),  32'd1);
    chk("lat3_sum_1C",      1, {24'd0, a_sum[1]}, 32'h1C);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
